// File: rtl/bypass_fifo.sv
// rtl/bypass_fifo.sv - show-ahead FIFO on a registered-read 1R1W RAM with collision bypass
module bypass_fifo #(
    parameter int RAM_DATA_WIDTH = 272,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DEPTH      = 256,
    parameter int AFULL_LEVEL    = 240
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [RAM_DATA_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RAM_DATA_WIDTH-1:0] out_data,
    output logic [RAM_ADDR_WIDTH:0]   count,
    output logic                      almost_full
);

    localparam logic [RAM_ADDR_WIDTH:0] DEPTH_C = (RAM_ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [RAM_ADDR_WIDTH:0] AFULL_C = (RAM_ADDR_WIDTH+1)'(AFULL_LEVEL);

    logic [RAM_DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_ADDR_WIDTH-1:0] wptr;
    logic [RAM_ADDR_WIDTH-1:0] rptr;
    logic [RAM_ADDR_WIDTH-1:0] rd_addr;
    logic [RAM_ADDR_WIDTH:0]   count_next;
    logic [RAM_DATA_WIDTH-1:0] ram_q;
    logic [RAM_DATA_WIDTH-1:0] byp_data;
    logic                      byp_sel;
    logic                      push;
    logic                      pop;
    logic                      coll;

    // Handshake flags decode only from registered count, so no input-to-output paths
    assign in_ready  = (count != DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Reading one ahead on pop keeps ram_q pointing at the new head next cycle
    assign rd_addr    = rptr + RAM_ADDR_WIDTH'(pop);
    assign coll       = push & (wptr == rd_addr);
    assign count_next = count + (RAM_ADDR_WIDTH+1)'(push) - (RAM_ADDR_WIDTH+1)'(pop);
    assign out_data   = byp_sel ? byp_data : ram_q;

    // Storage array: write port only, contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= in_data;
        end
    end

    // Registered read port; returns the stale word on a same-cycle write collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q <= '0;
        end else begin
            ram_q <= mem[rd_addr];
        end
    end

    // Pointers, occupancy and almost_full; flush discards the handshakes of its cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count       <= count_next;
            almost_full <= (count_next >= AFULL_C);
        end
    end

    // Bypass register covers the one cycle where ram_q would show stale data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else if (flush) begin
            byp_sel  <= 1'b0;
        end else begin
            byp_sel <= coll;
            if (coll) begin
                byp_data <= in_data;
            end
        end
    end

endmodule
